// File: rtl/jtag_seq.sv
// JTAG command sequencer: turns reset / IR / DR / idle-clock commands into TCK/TMS/TDI pad activity.
// Latency: an op of N TCKs takes 2*N*HP clk_i cycles, response valid one cycle after the last TCK.
// Backpressure: one op in flight; cmd_ready_o stays low until the response is taken on rsp_ready_i.
//
// Ports:
//   clk_i, rst_n_i (sync, active-low)     : clock / reset
//   cmd_valid_i/cmd_ready_o, cmd_op_i,
//   cmd_len_i, cmd_data_i                 : command channel (op 00 reset, 01 IR, 10 DR, 11 idle)
//   rsp_valid_o/rsp_ready_i, rsp_data_o,
//   rsp_err_o                             : response channel (captured TDO, reject flag)
//   tck_o, tms_o, tdi_o, tdo_i            : target TAP pads
//   div_i (only with JTAG_SEQ_DIV_EN)     : TCK half period = div_i+1 clk_i cycles
//
// Optional feature macro: JTAG_SEQ_DIV_EN (programmable TCK divider; default is TCK = clk_i/2).

module jtag_seq #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
`ifdef JTAG_SEQ_DIV_EN
    input  logic [7:0]         div_i,
`endif
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               rsp_err_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);

    typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, RUN, RESP} state_t;

    localparam logic [1:0] OP_RST  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_DR   = 2'b10;
    localparam logic [1:0] OP_IDLE = 2'b11;

    state_t             state_q;
    logic [1:0]         op_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;       // TCK index within the current state
    logic [MAX_LEN-1:0] data_q;      // TDI bits still to go, next bit at [0]
    logic [MAX_LEN-1:0] cap_q;       // TDO bits enter at the top, aligned at the end of the op
    logic [5:0]         pre_tms_q;   // remaining PRE TMS bits, current at [0]
    logic [2:0]         pre_last_q;  // index of the last PRE TCK
    logic [7:0]         hcnt_q;      // clk_i cycles left in the current TCK half
    logic               auto_q;      // running the post-reset sequence, no response
    logic [7:0]         hp_m1;       // half period minus one for the running op
    logic [7:0]         acc_hp_m1;   // half period minus one for a command being accepted

`ifdef JTAG_SEQ_DIV_EN
    logic [7:0]         div_q;
    assign hp_m1     = div_q;
    assign acc_hp_m1 = div_i;
`else
    assign hp_m1     = 8'd0;
    assign acc_hp_m1 = 8'd0;
`endif

    logic cmd_bad;
    logic op_done;

    always_comb begin
        cmd_bad = 1'b0;
        case (cmd_op_i)
            OP_IR, OP_DR: cmd_bad = (cmd_len_i == '0) || (int'(cmd_len_i) > MAX_LEN);
            OP_IDLE:      cmd_bad = (cmd_len_i == '0);
            default:      cmd_bad = 1'b0;
        endcase
    end

    // True during the last TCK of the whole op (SHIFT always hands over to POST).
    always_comb begin
        op_done = 1'b0;
        case (state_q)
            PRE:     op_done = (op_q == OP_RST) && (cnt_q == LEN_W'(pre_last_q));
            POST:    op_done = (cnt_q == LEN_W'(1));
            RUN:     op_done = (cnt_q == len_q - 1'b1);
            default: op_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            // Park the pads and arm the autonomous TAP reset for when reset lifts.
            state_q     <= PRE;
            op_q        <= OP_RST;
            len_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            pre_tms_q   <= 6'b011111;
            pre_last_q  <= 3'd5;
            hcnt_q      <= 8'd0;
            auto_q      <= 1'b1;
            tck_o       <= 1'b0;
            tms_o       <= 1'b1;
            tdi_o       <= 1'b0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
`ifdef JTAG_SEQ_DIV_EN
            div_q       <= 8'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        op_q        <= cmd_op_i;
                        len_q       <= cmd_len_i;
                        data_q      <= cmd_data_i;
                        cap_q       <= '0;
                        cnt_q       <= '0;
                        hcnt_q      <= acc_hp_m1;
                        auto_q      <= 1'b0;
                        tck_o       <= 1'b0;
                        tdi_o       <= 1'b0;
`ifdef JTAG_SEQ_DIV_EN
                        div_q       <= div_i;
`endif
                        if (cmd_bad) begin
                            state_q    <= RESP;
                            rsp_err_o  <= 1'b1;
                            rsp_data_o <= '0;
                        end else begin
                            rsp_err_o <= 1'b0;
                            case (cmd_op_i)
                                OP_RST: begin
                                    state_q    <= PRE;
                                    pre_tms_q  <= 6'b011111;
                                    pre_last_q <= 3'd5;
                                    tms_o      <= 1'b1;
                                end
                                OP_IR: begin
                                    state_q    <= PRE;
                                    pre_tms_q  <= 6'b000011;
                                    pre_last_q <= 3'd3;
                                    tms_o      <= 1'b1;
                                end
                                OP_DR: begin
                                    state_q    <= PRE;
                                    pre_tms_q  <= 6'b000001;
                                    pre_last_q <= 3'd2;
                                    tms_o      <= 1'b1;
                                end
                                default: begin
                                    state_q <= RUN;
                                    tms_o   <= 1'b0;
                                end
                            endcase
                        end
                    end
                end

                PRE, SHIFT, POST, RUN: begin
                    if (hcnt_q != 8'd0) begin
                        hcnt_q <= hcnt_q - 8'd1;
                    end else if (!tck_o) begin
                        // Low half over: rising TCK, TDO is sampled on this same cycle.
                        tck_o  <= 1'b1;
                        hcnt_q <= hp_m1;
                        if (state_q == SHIFT)
                            cap_q <= {tdo_i, cap_q[MAX_LEN-1:1]};
                    end else if (op_done) begin
                        tck_o  <= 1'b0;
                        tdi_o  <= 1'b0;
                        hcnt_q <= 8'd0;
                        if (auto_q) begin
                            auto_q      <= 1'b0;
                            state_q     <= IDLE;
                            cmd_ready_o <= 1'b1;
                        end else begin
                            state_q   <= RESP;
                            rsp_err_o <= 1'b0;
                            if (op_q == OP_IR || op_q == OP_DR)
                                rsp_data_o <= cap_q >> (MAX_LEN - int'(len_q));
                            else
                                rsp_data_o <= '0;
                        end
                    end else begin
                        // High half over: falling TCK, set up TMS/TDI for the next TCK.
                        tck_o  <= 1'b0;
                        hcnt_q <= hp_m1;
                        case (state_q)
                            PRE: begin
                                if (cnt_q == LEN_W'(pre_last_q)) begin
                                    state_q <= SHIFT;
                                    cnt_q   <= '0;
                                    tms_o   <= (len_q == LEN_W'(1));
                                    tdi_o   <= data_q[0];
                                end else begin
                                    cnt_q     <= cnt_q + 1'b1;
                                    tms_o     <= pre_tms_q[1];
                                    pre_tms_q <= pre_tms_q >> 1;
                                end
                            end
                            SHIFT: begin
                                if (cnt_q == len_q - 1'b1) begin
                                    state_q <= POST;
                                    cnt_q   <= '0;
                                    tms_o   <= 1'b1;
                                    tdi_o   <= 1'b0;
                                end else begin
                                    cnt_q  <= cnt_q + 1'b1;
                                    tms_o  <= (cnt_q + 1'b1 == len_q - 1'b1);
                                    tdi_o  <= data_q[1];
                                    data_q <= data_q >> 1;
                                end
                            end
                            default: begin
                                // POST second TCK and idle clocks both run at TMS=0.
                                cnt_q <= cnt_q + 1'b1;
                                tms_o <= 1'b0;
                            end
                        endcase
                    end
                end

                RESP: begin
                    // Valid rises the cycle after the final TCK edge, then waits for the consumer.
                    if (!rsp_valid_o) begin
                        rsp_valid_o <= 1'b1;
                    end else if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state_q     <= IDLE;
                        cmd_ready_o <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_seq.sv
// Directed bench for jtag_seq: TAP reset, IR/DR shifts, rejects, idle clocks, mid-op reset.
// Latency: n/a (bench).
// Backpressure: response is held with rsp_ready low before being consumed.

module tb_jtag_seq;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'b00;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err;
    logic               tck, tms, tdi, tdo;
    logic               tdo_loop = 1'b1;
    logic               tdo_const = 1'b0;
`ifdef JTAG_SEQ_DIV_EN
    logic [7:0]         div = 8'd0;
`endif

    assign tdo = tdo_loop ? tdi : tdo_const;

    always #5 clk = ~clk;

    jtag_seq #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_len_i   (cmd_len),
        .cmd_data_i  (cmd_data),
`ifdef JTAG_SEQ_DIV_EN
        .div_i       (div),
`endif
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .tck_o       (tck),
        .tms_o       (tms),
        .tdi_o       (tdi),
        .tdo_i       (tdo)
    );

    // Pad monitor, sampled on the falling clk edge.
    int          cyc = 0;
    int          tck_cnt = 0;
    int          rsp_cyc_cnt = 0;
    int          fall_cyc = 0;
    int          rsp_rise_cyc = 0;
    int          hi_run = 0;
    int          last_hi = 0;
    logic [63:0] tms_log = '0;
    logic        tck_prev = 1'b0;
    logic        rsp_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tck && !tck_prev) begin
            tck_cnt = tck_cnt + 1;
            tms_log = {tms_log[62:0], tms};
        end
        if (!tck && tck_prev) begin
            fall_cyc = cyc;
            last_hi  = hi_run;
        end
        hi_run = tck ? hi_run + 1 : 0;
        if (rsp_valid) rsp_cyc_cnt = rsp_cyc_cnt + 1;
        if (rsp_valid && !rsp_prev) rsp_rise_cyc = cyc;
        tck_prev = tck;
        rsp_prev = rsp_valid;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready && n < 1000) begin
            step();
            n++;
        end
        check({tag, " ready"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 2000) begin
            step();
            n++;
        end
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    endtask

    task automatic issue(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data);
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [63:0] mask(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    // Full op: checks TCK count, TMS pattern (first TCK at MSB), data, error and holding behaviour.
    task automatic run_op(input string tag, input logic [1:0] op, input int len,
                          input logic [MAX_LEN-1:0] data, input int exp_tcks,
                          input logic [63:0] exp_tms, input logic [MAX_LEN-1:0] exp_data,
                          input logic exp_err);
        int t0;
        wait_ready(tag);
        t0 = tck_cnt;
        issue(op, len, data);
        wait_rsp(tag);
        check({tag, " tcks"}, 64'(tck_cnt - t0), 64'(exp_tcks));
        if (exp_tcks > 0) begin
            check({tag, " tms"}, tms_log & mask(exp_tcks), exp_tms);
            check({tag, " rsp lat"}, 64'(rsp_rise_cyc - fall_cyc), 64'd1);
        end
        check({tag, " data"}, 64'(rsp_data), 64'(exp_data));
        check({tag, " err"}, 64'(rsp_err), 64'(exp_err));
        check({tag, " tck idle"}, 64'(tck), 64'd0);
        step();
        step();
        check({tag, " hold"}, {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, exp_data});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, " consumed"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pads/ctl"}, 64'({tck, tms, tdi, cmd_ready, rsp_valid, rsp_err}),
              64'(6'b010000));
        check({tag, " rsp_data"}, 64'(rsp_data), 64'd0);
    endtask

    task automatic check_auto_reset(input string tag);
        int t0, r0;
        t0 = tck_cnt;
        r0 = rsp_cyc_cnt;
        rst_n = 1'b1;
        wait_ready(tag);
        check({tag, " tcks"}, 64'(tck_cnt - t0), 64'd6);
        check({tag, " tms"}, tms_log & mask(6), 64'b111110);
        check({tag, " no rsp"}, 64'(rsp_cyc_cnt - r0), 64'd0);
        check({tag, " tck low"}, 64'(tck), 64'd0);
    endtask

    initial begin
        int t0, n;

        // Power-up reset and the autonomous TAP reset that follows.
        rst_n = 1'b0;
        step(); step(); step();
        check_reset_outputs("por");
        check_auto_reset("por auto");

        // DR shift with TDO looped back from TDI.
        tdo_loop = 1'b1;
        run_op("dr8", 2'b10, 8, 32'hA5, 13, 64'b1000000000110, 32'hA5, 1'b0);

        // IR shift with TDO tied high.
        tdo_loop  = 1'b0;
        tdo_const = 1'b1;
        run_op("ir4", 2'b01, 4, 32'h3, 10, 64'b1100000110, 32'hF, 1'b0);

        // Rejected lengths.
        run_op("dr0", 2'b10, 0, 32'hFFFF_FFFF, 0, 64'd0, 32'd0, 1'b1);
        run_op("dr33", 2'b10, 33, 32'hFFFF_FFFF, 0, 64'd0, 32'd0, 1'b1);
        run_op("idle0", 2'b11, 0, 32'd0, 0, 64'd0, 32'd0, 1'b1);

        // Full-width DR shift, TDO looped.
        tdo_loop = 1'b1;
        run_op("dr32", 2'b10, 32, 32'h8123_4567, 37, 64'b100_00000000000000000000000000000001_10,
               32'h8123_4567, 1'b0);

        // Idle clocks, then consume the response in the same cycle a new command is offered.
        wait_ready("idle3");
        t0 = tck_cnt;
        issue(2'b11, 3, 32'hFFFF_FFFF);
        wait_rsp("idle3");
        check("idle3 tcks", 64'(tck_cnt - t0), 64'd3);
        check("idle3 tms", tms_log & mask(3), 64'b000);
        check("idle3 data", 64'(rsp_data), 64'd0);
        cmd_op    = 2'b00;
        cmd_len   = '0;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("overlap rsp gone", 64'(rsp_valid), 64'd0);
        check("overlap ready", 64'(cmd_ready), 64'd1);
        t0 = tck_cnt;
        step();
        cmd_valid = 1'b0;
        wait_rsp("tap rst");
        check("tap rst tcks", 64'(tck_cnt - t0), 64'd6);
        check("tap rst tms", tms_log & mask(6), 64'b111110);
        check("tap rst err", 64'(rsp_err), 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

`ifdef JTAG_SEQ_DIV_EN
        // Divided TCK: half period of 4 clk_i cycles.
        wait_ready("div");
        div = 8'd3;
        n = cyc;
        issue(2'b11, 2, 32'd0);
        div = 8'd0;
        wait_rsp("div");
        check("div hi len", 64'(last_hi), 64'd4);
        check("div total", 64'(fall_cyc - n - 1), 64'd16);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`endif

        // Reset in the middle of SHIFT with the response side stalled.
        wait_ready("abort");
        t0 = tck_cnt;
        issue(2'b10, 16, 32'h0000_FFFF);
        n = 0;
        while ((tck_cnt - t0) < 6 && n < 200) begin
            step();
            n++;
        end
        check("abort reached shift", 64'((tck_cnt - t0) >= 6), 64'd1);
        rst_n = 1'b0;
        step();
        step();
        check_reset_outputs("abort");
        check_auto_reset("abort auto");
        check("abort no stale rsp", 64'(rsp_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
